// File: rtl/irst_misr_collector.sv
// ---------------------------------------------------------------------------
// irst_misr_collector
//
// After the register file finishes its initial-reset sequence, this block
// walks every register through a dedicated read port and folds the contents
// into a MISR signature. The signature is published on rand_data and stays
// there until a later collection completes and replaces it.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   irst_done      in   register file initial-reset complete (level)
//   irst_reg_data  in   register contents at irst_rd_addr (combinational)
//   irst_rd_addr   out  register index being sampled (0 outside COLLECT)
//   rearm          in   single-cycle request to leave DONE for IDLE
//   busy           out  high while collecting
//   rand_data      out  completed signature, held after completion
//   rand_valid     out  high while rand_data holds a completed signature
//
// States
//   state   | meaning
//   IDLE    | waiting for irst_done
//   COLLECT | absorbing one register per cycle, cnt = register index
//   DONE    | signature published, waiting for rearm
// ---------------------------------------------------------------------------
module irst_misr_collector #(
    parameter int                    NUM_REGS   = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    SIG_WIDTH  = 32,
    parameter logic [SIG_WIDTH-1:0]  SEED       = 32'h0000_0000,
    parameter logic [SIG_WIDTH-1:0]  POLY       = 32'h04C1_1DB7,
    parameter int                    ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  irst_done,
    input  logic [DATA_WIDTH-1:0] irst_reg_data,
    output logic [ADDR_W-1:0]     irst_rd_addr,
    input  logic                  rearm,
    output logic                  busy,
    output logic [SIG_WIDTH-1:0]  rand_data,
    output logic                  rand_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0]   sig_q, sig_d;
    logic                   busy_q, busy_d;
    logic [SIG_WIDTH-1:0]   rand_data_q, rand_data_d;
    logic                   rand_valid_q, rand_valid_d;
    logic [SIG_WIDTH-1:0]   sig_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sig_q        <= SEED;
            busy_q       <= 1'b0;
            rand_data_q  <= '0;
            rand_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sig_q        <= sig_d;
            busy_q       <= busy_d;
            rand_data_q  <= rand_data_d;
            rand_valid_q <= rand_valid_d;
        end
    end

    always_comb begin
        // One MISR step: shift, fold the outgoing MSB back through POLY,
        // then XOR in the zero-extended register word.
        sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                 ^ {{(SIG_WIDTH-DATA_WIDTH){1'b0}}, irst_reg_data};

        state_d      = state_q;
        cnt_d        = cnt_q;
        sig_d        = sig_q;
        busy_d       = busy_q;
        rand_data_d  = rand_data_q;
        rand_valid_d = rand_valid_q;
        irst_rd_addr = '0;

        case (state_q)
            IDLE: begin
                if (irst_done) begin
                    state_d      = COLLECT;
                    cnt_d        = '0;
                    sig_d        = SEED;
                    busy_d       = 1'b1;
                    rand_valid_d = 1'b0;
                end
            end
            COLLECT: begin
                // irst_done and rearm are deliberately ignored here: once a
                // scan starts it always runs to completion (or reset).
                irst_rd_addr = cnt_q;
                sig_d        = sig_next;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    rand_data_d  = sig_next;
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    rand_valid_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            DONE: begin
                // rand_data is kept on rearm so the last signature stays
                // visible until a new one replaces it.
                if (rearm) begin
                    state_d      = IDLE;
                    rand_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = '0;
                busy_d       = 1'b0;
                rand_valid_d = 1'b0;
            end
        endcase
    end

    assign busy       = busy_q;
    assign rand_data  = rand_data_q;
    assign rand_valid = rand_valid_q;

endmodule

// File: tb/tb_irst_misr_collector.sv
module tb_irst_misr_collector;

    localparam logic [31:0] POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] SEED0 = 32'h0000_0000;
    localparam logic [31:0] SEED1 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irst_done = 1'b0;
    logic        rearm = 1'b0;
    logic [15:0] regs [8];

    logic [2:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic        busy0, busy1, valid0, valid1;
    logic [31:0] rdata0, rdata1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Register file stand-in: combinational read of the addressed register.
    assign data0 = regs[addr0];
    assign data1 = regs[addr1];

    irst_misr_collector #(.SEED(SEED0)) dut (
        .clk(clk), .rst(rst), .irst_done(irst_done), .irst_reg_data(data0),
        .irst_rd_addr(addr0), .rearm(rearm), .busy(busy0),
        .rand_data(rdata0), .rand_valid(valid0)
    );

    irst_misr_collector #(.SEED(SEED1)) dut_s (
        .clk(clk), .rst(rst), .irst_done(irst_done), .irst_reg_data(data1),
        .irst_rd_addr(addr1), .rearm(rearm), .busy(busy1),
        .rand_data(rdata1), .rand_valid(valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signature of the whole register array, straight from the MISR rule.
    function automatic logic [31:0] misr_sig(input logic [31:0] seed);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < 8; i++)
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ {16'h0, regs[i]};
        return s;
    endfunction

    // Transaction-level model: phase 0 idle, 1 scanning, 2 result held.
    int          phase [2];
    int          absorbed [2];
    logic [31:0] m_data [2];
    logic        m_valid [2];
    logic [31:0] seeds [2];

    initial begin
        seeds[0] = SEED0;
        seeds[1] = SEED1;
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; absorbed[d] = 0; m_data[d] = '0; m_valid[d] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                phase[d] = 0; absorbed[d] = 0; m_data[d] = '0; m_valid[d] = 1'b0;
            end else if (phase[d] == 0) begin
                if (irst_done) begin
                    phase[d] = 1; absorbed[d] = 0; m_valid[d] = 1'b0;
                end
            end else if (phase[d] == 1) begin
                absorbed[d]++;
                if (absorbed[d] == 8) begin
                    phase[d] = 2; absorbed[d] = 0;
                    m_data[d] = misr_sig(seeds[d]);
                    m_valid[d] = 1'b1;
                end
            end else if (rearm) begin
                phase[d] = 0; m_valid[d] = 1'b0;
            end
        end
        #1;
        chk("addr0",  {29'h0, addr0}, (phase[0] == 1) ? 32'(absorbed[0]) : 32'h0);
        chk("busy0",  {31'h0, busy0}, {31'h0, phase[0] == 1});
        chk("valid0", {31'h0, valid0}, {31'h0, m_valid[0]});
        chk("data0",  rdata0, m_data[0]);
        chk("addr1",  {29'h0, addr1}, (phase[1] == 1) ? 32'(absorbed[1]) : 32'h0);
        chk("busy1",  {31'h0, busy1}, {31'h0, phase[1] == 1});
        chk("valid1", {31'h0, valid1}, {31'h0, m_valid[1]});
        chk("data1",  rdata1, m_data[1]);
    end

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (valid0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_valid: got valid=0 expected valid=1 within 20 cycles");
        end
    endtask

    task automatic set_regs(input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7);
        regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
        regs[4] = r4; regs[5] = r5; regs[6] = r6; regs[7] = r7;
    endtask

    task automatic pulse_start();
        @(negedge clk); irst_done = 1'b1;
        @(negedge clk); irst_done = 1'b0;
    endtask

    task automatic do_rearm();
        @(negedge clk); rearm = 1'b1;
        @(negedge clk); rearm = 1'b0;
    endtask

    logic [31:0] saved;
    bit          hit;

    initial begin
        set_regs(0, 0, 0, 0, 0, 0, 0, 0);
        irst_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr",  {29'h0, addr0}, 32'h0);
        chk("rst_busy",  {31'h0, busy0}, 32'h0);
        chk("rst_data",  rdata0, 32'h0);
        chk("rst_valid", {31'h0, valid0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("start_after_rst", {31'h0, busy0}, 32'h1);
        irst_done = 1'b0;
        wait_valid();
        chk("zero_sig", rdata0, 32'h0000_0000);
        do_rearm();

        set_regs(0, 0, 0, 0, 0, 0, 0, 16'h0001);
        pulse_start();
        wait_valid();
        chk("r7_bit0", rdata0, 32'h0000_0001);
        do_rearm();

        set_regs(0, 0, 0, 0, 0, 0, 16'h0001, 0);
        pulse_start();
        wait_valid();
        chk("r6_bit0", rdata0, 32'h0000_0002);
        do_rearm();

        set_regs(16'h8000, 0, 0, 0, 0, 0, 0, 0);
        pulse_start();
        wait_valid();
        chk("r0_bit15", rdata0, 32'h0040_0000);
        do_rearm();

        // Abort at cnt=4 with reset, then rescan the same contents.
        set_regs(16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF, 16'h8001, 16'h5555, 16'hAAAA, 16'h0042);
        pulse_start();
        hit = 1'b0;
        for (int n = 0; n < 12 && !hit; n++) begin
            if (busy0 && addr0 == 3'd4) hit = 1'b1;
            else @(negedge clk);
        end
        chk("reach_cnt4", {31'h0, hit}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", {31'h0, valid0}, 32'h0);
        chk("abort_busy",  {31'h0, busy0}, 32'h0);
        chk("abort_data",  rdata0, 32'h0);
        pulse_start();
        wait_valid();
        chk("rescan_sig", rdata0, misr_sig(SEED0));
        do_rearm();

        // Drop irst_done mid-scan: the scan must still finish.
        set_regs(16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000, 16'h7FFF, 16'h0000, 16'hC3C3, 16'h1111);
        @(negedge clk); irst_done = 1'b1;
        repeat (3) @(negedge clk);
        irst_done = 1'b0;
        wait_valid();
        saved = rdata0;

        // Register contents changing while DONE must not disturb the result.
        set_regs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0003, 16'h0003, 16'h0003, 16'h0003);
        irst_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_hold", rdata0, saved);

        // Rearm with irst_done still high: IDLE for one edge, then a new scan.
        rearm = 1'b1;
        @(negedge clk); rearm = 1'b0;
        chk("rearm_valid_low", {31'h0, valid0}, 32'h0);
        chk("rearm_data_kept", rdata0, saved);
        @(negedge clk);
        chk("rearm_restart", {31'h0, busy0}, 32'h1);
        irst_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("scan_data_kept", rdata0, saved);
        wait_valid();
        chk("rearm_new_sig", rdata0, misr_sig(SEED0));
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irst_misr_collector.md
Name: irst_misr_collector

Overview:
- Consumes the register file's power-up state after its initial-reset sequence completes (irst_done, irst_reg_data).
- Walks all registers through a dedicated read address and compresses the 8 x 16-bit contents into a 32-bit signature using a MISR.
- Presents the result on rand_data for the core and the test fixture's result dump.
- Sits directly downstream of register_file.

Parameters:
- NUM_REGS, 8, registers scanned; address width is clog2(NUM_REGS) = 3.
- DATA_WIDTH, 16, width of irst_reg_data.
- SIG_WIDTH, 32, signature width.
- SEED, 32'h0000_0000, value loaded into the MISR at start of a collection.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial (bit 31 is the tap source).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- irst_done  in  1  register file initial-reset sequence complete (level).
- irst_reg_data  in  16  register contents at irst_rd_addr, combinational from the register file.
- irst_rd_addr  out  3  register index being sampled.
- rearm  in  1  single-cycle request to return to IDLE from DONE.
- busy  out  1  high while collecting.
- rand_data  out  32  signature; held stable after completion.
- rand_valid  out  1  high while rand_data holds a completed signature.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, cnt=0, sig=SEED.
  - Outputs: irst_rd_addr=0, busy=0, rand_data=0, rand_valid=0.
  - Reset overrides every other input and aborts any collection in progress; no partial signature is ever published.
- States: IDLE, COLLECT, DONE (registered state, 2 bits).
- IDLE:
  - irst_done=1 at an edge: go to COLLECT, cnt<=0, sig<=SEED, busy<=1, rand_valid<=0.
  - irst_done is level-sensitive. If it is already high on the first edge after reset deasserts, collection starts on that edge.
- COLLECT:
  - irst_rd_addr = cnt (combinational from cnt).
  - Each edge: sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ {16'b0, irst_reg_data}; cnt <= cnt+1.
  - irst_done is ignored in this state; dropping it does not abort.
  - rearm is ignored in this state.
  - Exactly NUM_REGS absorb edges per collection.
  - On the edge absorbing cnt=NUM_REGS-1:
    - rand_data <= the updated sig value (same value written into sig);
    - state<=DONE, busy<=0, rand_valid<=1, cnt<=0.
- Latency: start edge E, absorb edges E+1..E+8; rand_valid is first high after edge E+8.
- DONE:
  - rand_data and rand_valid are held; irst_rd_addr=0.
  - rearm=1 at an edge: go to IDLE, rand_valid<=0, rand_data kept.
  - If irst_done is still high, the next edge restarts collection (intended re-sample).
- irst_rd_addr is 0 in IDLE and DONE.
- cnt is 3 bits and never wraps mid-collection; the terminal check is cnt==NUM_REGS-1.
- All arithmetic is XOR/shift, with no carries. The data word is zero-extended into sig[15:0].

Test Plan:
- Reset: hold rst 3 cycles with irst_done=1 → irst_rd_addr=0, busy=0, rand_data=0, rand_valid=0. First edge with rst=0 enters COLLECT (busy=1).
- Zero data: SEED=0, all regs 0, pulse irst_done → irst_rd_addr steps 0..7 on consecutive cycles, busy high 8 cycles, then rand_valid=1 and rand_data=32'h0000_0000.
- Single-bit injection, two cases:
  - R7=16'h0001, others 0 → rand_data=32'h0000_0001.
  - R6=16'h0001, others 0 → rand_data=32'h0000_0002.
  - Either case with R0=16'h8000 instead → bit 15 shifted 7 → rand_data=32'h0040_0000.
- Feedback tap: SEED=32'h8000_0000, all regs 0 → first absorb gives sig=POLY. Final rand_data equals POLY advanced 7 further MISR steps with zero data, checked against a bench reference model.
- Abort and hold:
  - Assert rst at cnt=4 → rand_valid stays 0 and returns to IDLE; re-collection gives the full-scan result.
  - Drop irst_done mid-COLLECT → completes normally.
  - In DONE, change irst_reg_data → rand_data unchanged.
- Rearm: in DONE, pulse rearm with irst_done=1 → rand_valid falls next cycle. Recollection starts the following edge, and rand_data (previous value) holds until the new completion.
